ta_param_writer: RTL and testbench



---
 rtl/ta_param_writer.sv | 180 ++++++++++++++++++
 tb/tb_ta_param_writer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ta_param_writer.sv
// ta_param_writer: serialises one triangle (header + 3 vertices) into VRAM
// parameter memory and emits the matching object-list word on completion.
module ta_param_writer #(
    parameter int ADDR_W = 24
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic [31:0]       isp_inst,
    input  logic [31:0]       tsp_inst,
    input  logic [31:0]       tex_cont,
    input  logic              shadow,
    input  logic [ADDR_W-1:0] param_ptr,
    input  logic [ADDR_W-1:0] param_limit,
    input  logic              vin_valid,
    input  logic [31:0]       vin_data,
    output logic              vin_ready,
    output logic              vram_wr,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [31:0]       vram_dout,
    input  logic              vram_wait,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [31:0]       ol_word,
    output logic [ADDR_W-1:0] next_ptr
);
    typedef enum logic [1:0] {IDLE, HDR, VTX, DONE} state_t;
    state_t state_q, state_d;
    logic pend_q, pend_d, last_q, last_d, ovf_q, ovf_d;
    logic tex_q, tex_d, uv16_q, uv16_d, off_q, off_d, shadow_q, shadow_d;
    logic [ADDR_W-1:0] addr_q, addr_d, ptr_q, ptr_d, next_ptr_q, next_ptr_d;
    logic [31:0] data_q, data_d, tsp_q, tsp_d, texw_q, texw_d, ol_q, ol_d;
    logic [1:0] hidx_q, hidx_d, vidx_q, vidx_d;
    logic [2:0] widx_q, widx_d, vw_in, vw, skip;
    logic [4:0] total_in, total;
    logic [ADDR_W-1:0] ptr_in;
    logic [ADDR_W:0] end_in;
    logic fits, complete, free, accept, keep;

    function automatic logic [2:0] vert_words(input logic t, input logic u, input logic o);
        return 3'd4 + (t ? (u ? 3'd1 : 3'd2) : 3'd0) + {2'b00, o};
    endfunction

    assign vw_in = vert_words(isp_inst[25], isp_inst[22], isp_inst[24]);
    assign vw = vert_words(tex_q, uv16_q, off_q);
    assign skip = vw - 3'd3;
    assign total_in = 5'd3 + 5'd3 * {2'b00, vw_in};
    assign total = 5'd3 + 5'd3 * {2'b00, vw};
    assign ptr_in = {param_ptr[ADDR_W-1:2], 2'b00};
    assign end_in = {1'b0, ptr_in} + (ADDR_W+1)'({total_in, 2'b00});
    assign fits = end_in <= {1'b0, param_limit};
    // One-entry output register: a new word may load when empty or draining now
    assign complete = pend_q && !vram_wait;
    assign free = !pend_q || !vram_wait;
    assign vin_ready = (state_q == VTX) && free;
    assign accept = vin_valid && vin_ready;
    assign keep = widx_q < 3'd3 || widx_q == 3'd5 || (widx_q == 3'd3 && tex_q)
                || (widx_q == 3'd4 && tex_q && !uv16_q) || (widx_q == 3'd6 && off_q);

    assign vram_wr = pend_q;
    assign vram_addr = addr_q;
    assign vram_dout = data_q;
    assign busy = state_q == HDR || state_q == VTX;
    assign done = state_q == DONE;
    assign overflow = ovf_q;
    assign ol_word = ol_q;
    assign next_ptr = next_ptr_q;

    always_comb begin
        state_d = state_q;
        pend_d = pend_q;
        last_d = last_q;
        ovf_d = 1'b0;
        tex_d = tex_q;
        uv16_d = uv16_q;
        off_d = off_q;
        shadow_d = shadow_q;
        addr_d = addr_q;
        ptr_d = ptr_q;
        next_ptr_d = next_ptr_q;
        data_d = data_q;
        tsp_d = tsp_q;
        texw_d = texw_q;
        ol_d = ol_q;
        hidx_d = hidx_q;
        vidx_d = vidx_q;
        widx_d = widx_q;
        case (state_q)
            IDLE: if (start) begin
                tex_d = isp_inst[25];
                off_d = isp_inst[24];
                uv16_d = isp_inst[22];
                shadow_d = shadow;
                tsp_d = tsp_inst;
                texw_d = tex_cont;
                ptr_d = ptr_in;
                ovf_d = !fits;
                if (fits) begin
                    state_d = HDR;
                    pend_d = 1'b1;
                    data_d = isp_inst;
                    addr_d = ptr_in;
                    hidx_d = 2'd1;
                end
            end
            // Header register is always full here, so each completion loads the next word
            HDR: if (complete) begin
                addr_d = addr_q + ADDR_W'(4);
                data_d = hidx_q == 2'd1 ? tsp_q : texw_q;
                hidx_d = hidx_q + 2'd1;
                if (hidx_q == 2'd2) state_d = VTX;
            end
            VTX: begin
                addr_d = complete ? addr_q + ADDR_W'(4) : addr_q;
                pend_d = complete ? 1'b0 : pend_q;
                if (accept) begin
                    widx_d = widx_q == 3'd6 ? 3'd0 : widx_q + 3'd1;
                    if (widx_q == 3'd6) begin
                        vidx_d = vidx_q == 2'd2 ? 2'd0 : vidx_q + 2'd1;
                        last_d = vidx_q == 2'd2;
                    end
                    if (keep) begin
                        pend_d = 1'b1;
                        data_d = vin_data;
                    end
                end
                if (last_d && !pend_d) begin
                    state_d = DONE;
                    last_d = 1'b0;
                    next_ptr_d = ptr_q + ADDR_W'({total, 2'b00});
                    ol_d = {3'b100, 4'd0, shadow_q, skip, ptr_q[22:2]};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pend_q <= 1'b0;
            last_q <= 1'b0;
            ovf_q <= 1'b0;
            tex_q <= 1'b0;
            uv16_q <= 1'b0;
            off_q <= 1'b0;
            shadow_q <= 1'b0;
            addr_q <= '0;
            ptr_q <= '0;
            next_ptr_q <= '0;
            data_q <= '0;
            tsp_q <= '0;
            texw_q <= '0;
            ol_q <= '0;
            hidx_q <= '0;
            vidx_q <= '0;
            widx_q <= '0;
        end else begin
            state_q <= state_d;
            pend_q <= pend_d;
            last_q <= last_d;
            ovf_q <= ovf_d;
            tex_q <= tex_d;
            uv16_q <= uv16_d;
            off_q <= off_d;
            shadow_q <= shadow_d;
            addr_q <= addr_d;
            ptr_q <= ptr_d;
            next_ptr_q <= next_ptr_d;
            data_q <= data_d;
            tsp_q <= tsp_d;
            texw_q <= texw_d;
            ol_q <= ol_d;
            hidx_q <= hidx_d;
            vidx_q <= vidx_d;
            widx_q <= widx_d;
        end
    end
endmodule

// File: tb/tb_ta_param_writer.sv
// tb_ta_param_writer: random triangles against a write-list model of the
// parameter layout, plus overflow, stall and mid-triangle reset cases.
module tb_ta_param_writer;
    localparam int AW = 24;
    logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, shadow = 1'b0;
    logic vin_valid = 1'b0, vram_wait = 1'b0;
    logic [31:0] isp_inst = '0, tsp_inst = '0, tex_cont = '0, vin_data = '0;
    logic [AW-1:0] param_ptr = '0, param_limit = '0;
    logic vin_ready, vram_wr, busy, done, overflow;
    logic [AW-1:0] vram_addr, next_ptr;
    logic [31:0] vram_dout, ol_word;
    int checks = 0, fails = 0;
    logic [AW-1:0] exp_a[$];
    logic [31:0] exp_d[$];
    logic [31:0] vwords[21];

    ta_param_writer #(.ADDR_W(AW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .isp_inst(isp_inst),
        .tsp_inst(tsp_inst), .tex_cont(tex_cont), .shadow(shadow),
        .param_ptr(param_ptr), .param_limit(param_limit), .vin_valid(vin_valid),
        .vin_data(vin_data), .vin_ready(vin_ready), .vram_wr(vram_wr),
        .vram_addr(vram_addr), .vram_dout(vram_dout), .vram_wait(vram_wait),
        .busy(busy), .done(done), .overflow(overflow), .ol_word(ol_word),
        .next_ptr(next_ptr)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Expected write list: header, then each vertex word unless the format omits it
    task automatic build(input logic [31:0] isp, input logic [AW-1:0] ptr);
        logic [AW-1:0] a;
        bit tex, off, uv, drop;
        tex = isp[25];
        off = isp[24];
        uv = isp[22];
        a = {ptr[AW-1:2], 2'b00};
        exp_a.delete();
        exp_d.delete();
        exp_a.push_back(a); exp_d.push_back(isp); a += 4;
        exp_a.push_back(a); exp_d.push_back(tsp_inst); a += 4;
        exp_a.push_back(a); exp_d.push_back(tex_cont); a += 4;
        for (int v = 0; v < 3; v++)
            for (int w = 0; w < 7; w++) begin
                drop = (w == 3 && !tex) || (w == 4 && (!tex || uv)) || (w == 6 && !off);
                if (!drop) begin
                    exp_a.push_back(a);
                    exp_d.push_back(vwords[v*7+w]);
                    a += 4;
                end
            end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " vram_wr"}, 32'(vram_wr), 0);
        chk({tag, " busy"}, 32'(busy), 0);
        chk({tag, " done"}, 32'(done), 0);
        chk({tag, " overflow"}, 32'(overflow), 0);
        chk({tag, " vin_ready"}, 32'(vin_ready), 0);
        chk({tag, " ol_word"}, ol_word, 0);
        chk({tag, " next_ptr"}, 32'(next_ptr), 0);
    endtask

    task automatic run_tri(input logic [31:0] isp, input logic [AW-1:0] ptr, input bit shd,
                           input int wait_pct, input int gap_pct, input int stall_word,
                           input int abort_at);
        int n, vi, stall, words, skip;
        bit got_done, aborted;
        logic [AW-1:0] pa;
        for (int i = 0; i < 21; i++) vwords[i] = $urandom;
        isp_inst = isp;
        tsp_inst = $urandom;
        tex_cont = $urandom;
        shadow = shd;
        param_ptr = ptr | AW'($urandom_range(0, 3));
        pa = {ptr[AW-1:2], 2'b00};
        build(isp, ptr);
        words = exp_a.size();
        skip = (words - 3) / 3 - 3;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        n = 0; vi = 0; stall = 0; got_done = 0; aborted = 0;
        for (int cyc = 0; cyc < 1000 && !got_done && !aborted; cyc++) begin
            vram_wait = (n == stall_word && stall < 3) ? 1'b1 : ($urandom_range(0, 99) < wait_pct);
            vin_valid = vi < 21 && $urandom_range(0, 99) >= gap_pct;
            vin_data = vin_valid ? vwords[vi] : $urandom;
            @(negedge clock);
            if (vram_wr) begin
                if (n < words) begin
                    chk("write addr", 32'(vram_addr), 32'(exp_a[n]));
                    chk("write data", vram_dout, exp_d[n]);
                end else chk("extra write", 1, 0);
                if (vram_wait) begin
                    chk("vin_ready stalled", 32'(vin_ready), 0);
                    if (n == stall_word) stall++;
                end else n++;
            end
            if (vin_valid && vin_ready) vi++;
            if (done) begin
                got_done = 1;
                chk("busy at done", 32'(busy), 0);
                chk("write count", n, words);
                chk("vertex words consumed", vi, 21);
                chk("ol_word", ol_word, {3'b100, 4'd0, shd, 3'(skip), pa[22:2]});
                chk("next_ptr", 32'(next_ptr), 32'(pa + AW'(4 * words)));
            end else if (abort_at >= 0 && n >= abort_at) begin
                aborted = 1;
                reset_n = 1'b0;
                #1;
                check_idle_outputs("abort");
            end
            @(posedge clock); #1;
        end
        vin_valid = 1'b0;
        vram_wait = 1'b0;
        if (aborted) reset_n = 1'b1;
        else if (!got_done) chk("done timeout", 0, 1);
        @(negedge clock);
        chk("done one cycle", 32'(done), 0);
        @(posedge clock); #1;
    endtask

    task automatic ovf_case(input logic [31:0] isp, input logic [AW-1:0] ptr,
                            input logic [AW-1:0] lim);
        isp_inst = isp;
        param_ptr = ptr;
        param_limit = lim;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        @(negedge clock);
        chk("overflow pulse", 32'(overflow), 1);
        chk("overflow busy", 32'(busy), 0);
        chk("overflow vram_wr", 32'(vram_wr), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("overflow after", 32'(overflow), 0);
            chk("overflow idle busy", 32'(busy), 0);
            chk("overflow idle vram_wr", 32'(vram_wr), 0);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        #1;
        check_idle_outputs("reset");
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        param_limit = 24'hFFFFFF;
        run_tri(32'h0, 24'h1000, 0, 0, 0, -1, -1);
        chk("plain ol_word", ol_word, 32'h80200400);
        chk("plain next_ptr", 32'(next_ptr), 32'h103C);
        run_tri(($urandom & ~32'h0340_0000) | 32'h0300_0000, 24'h2000, 1, 0, 0, -1, -1);
        chk("tex+off skip", 32'(ol_word[23:21]), 4);
        chk("tex+off next_ptr", 32'(next_ptr), 32'h2060);
        run_tri(32'h0240_0000, 24'h3000, 0, 20, 20, -1, -1);
        chk("uv16 vertex B X addr", 32'(exp_a[8]), 32'h3020);
        chk("uv16 skip", 32'(ol_word[23:21]), 2);
        run_tri(32'h0, 24'h4000, 0, 0, 0, 5, -1);
        for (int t = 0; t < 8; t++)
            run_tri($urandom, AW'($urandom_range(0, 24'h7FFF00)), 1'($urandom), 30, 30, -1, -1);
        ovf_case(32'h0, 24'h1FF0, 24'h2000);
        ovf_case(32'h0300_0000, 24'h1FC4, 24'h2000);
        param_limit = 24'h2000;
        run_tri(32'h0, 24'h1FC4, 0, 10, 10, -1, -1);
        param_limit = 24'hFFFFFF;
        run_tri(32'h0, 24'h5000, 0, 0, 0, -1, 8);
        run_tri(32'h0, 24'h5000, 0, 0, 0, -1, -1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
